// File: rtl/aes_frame_ctrl.sv
// SPI-to-AES request controller: latches one request frame, decodes mode and key length,
// runs a start/done transaction on the AES core and builds the response frame with status.
module aes_frame_ctrl #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned KEY_W   = 256,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned FRAME_W = DATA_W + CTRL_W + KEY_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [FRAME_W-1:0] rx_frame,
  output logic [FRAME_W-1:0] tx_frame,
  output logic               tx_load,
  output logic               core_start,
  output logic               core_decrypt,
  output logic [1:0]         core_keylen,
  output logic [DATA_W-1:0]  core_data,
  output logic [KEY_W-1:0]   core_key,
  input  logic               core_done,
  input  logic [DATA_W-1:0]  core_result,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam int unsigned LEN_W = CTRL_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 overrun_q, overrun_d;
  logic [FRAME_W-1:0]   tx_frame_q, tx_frame_d;
  logic                 tx_load_q, tx_load_d;
  logic                 core_start_q, core_start_d;
  logic                 core_decrypt_q, core_decrypt_d;
  logic [1:0]           core_keylen_q, core_keylen_d;
  logic [DATA_W-1:0]    core_data_q, core_data_d;
  logic [KEY_W-1:0]     core_key_q, core_key_d;
  logic                 busy_q, busy_d;

  logic [CTRL_W-1:0]    ctrl_c;
  logic [LEN_W-1:0]     len_c;
  logic                 len_ok_c;
  logic [1:0]           keylen_c;
  logic                 ovr_c;

  // Response frame: result in data field, status in ctrl field, key field zero.
  function automatic logic [FRAME_W-1:0] build_tx(input logic [DATA_W-1:0] res,
                                                   input logic [CTRL_W-1:0] st);
    return {res, st, KEY_W'(0)};
  endfunction

  function automatic logic [CTRL_W-1:0] status(input logic ok, input logic badlen,
                                               input logic tmo, input logic ovr);
    logic [CTRL_W-1:0] s;
    s    = '0;
    s[0] = ok;
    s[1] = badlen;
    s[2] = tmo;
    s[3] = ovr;
    return s;
  endfunction

  // Control byte decode of the latched frame.
  always_comb begin
    ctrl_c   = frame_q[KEY_W +: CTRL_W];
    len_c    = ctrl_c[LEN_W-1:0];
    len_ok_c = 1'b0;
    keylen_c = 2'd0;
    if (len_c == LEN_W'(16)) begin
      len_ok_c = 1'b1;
      keylen_c = 2'd0;
    end else if (len_c == LEN_W'(24)) begin
      len_ok_c = 1'b1;
      keylen_c = 2'd1;
    end else if (len_c == LEN_W'(32)) begin
      len_ok_c = 1'b1;
      keylen_c = 2'd2;
    end
  end

  // A frame arriving while not idle is dropped but must still show in the next status.
  assign ovr_c = overrun_q | (rx_valid && (state_q != ST_IDLE));

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    cnt_d          = cnt_q;
    overrun_d      = ovr_c;
    tx_frame_d     = tx_frame_q;
    tx_load_d      = 1'b0;
    core_start_d   = 1'b0;
    core_decrypt_d = core_decrypt_q;
    core_keylen_d  = core_keylen_q;
    core_data_d    = core_data_q;
    core_key_d     = core_key_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          frame_d = rx_frame;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (len_ok_c) begin
          core_data_d    = frame_q[FRAME_W-1 -: DATA_W];
          core_key_d     = frame_q[KEY_W-1:0];
          core_decrypt_d = ctrl_c[CTRL_W-1];
          core_keylen_d  = keylen_c;
          core_start_d   = 1'b1;
          cnt_d          = '0;
          state_d        = ST_RUN;
        end else begin
          tx_frame_d = build_tx('0, status(1'b0, 1'b1, 1'b0, ovr_c));
          tx_load_d  = 1'b1;
          overrun_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          tx_frame_d = build_tx(core_result, status(1'b1, 1'b0, 1'b0, ovr_c));
          tx_load_d  = 1'b1;
          overrun_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tx_frame_d = build_tx('0, status(1'b0, 1'b0, 1'b1, ovr_c));
          tx_load_d  = 1'b1;
          overrun_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      cnt_q          <= '0;
      overrun_q      <= 1'b0;
      tx_frame_q     <= '0;
      tx_load_q      <= 1'b0;
      core_start_q   <= 1'b0;
      core_decrypt_q <= 1'b0;
      core_keylen_q  <= 2'd0;
      core_data_q    <= '0;
      core_key_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      cnt_q          <= cnt_d;
      overrun_q      <= overrun_d;
      tx_frame_q     <= tx_frame_d;
      tx_load_q      <= tx_load_d;
      core_start_q   <= core_start_d;
      core_decrypt_q <= core_decrypt_d;
      core_keylen_q  <= core_keylen_d;
      core_data_q    <= core_data_d;
      core_key_q     <= core_key_d;
      busy_q         <= busy_d;
    end
  end

  assign tx_frame     = tx_frame_q;
  assign tx_load      = tx_load_q;
  assign core_start   = core_start_q;
  assign core_decrypt = core_decrypt_q;
  assign core_keylen  = core_keylen_q;
  assign core_data    = core_data_q;
  assign core_key     = core_key_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_aes_frame_ctrl.sv
// Directed bench for aes_frame_ctrl: the AES core is stood in for by the bench,
// returning FIPS-197 known-answer blocks after a chosen number of cycles.
module tb_aes_frame_ctrl;

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned FRAME_W = DATA_W + CTRL_W + KEY_W;
  localparam int unsigned TIMEOUT = 64;

  localparam logic [DATA_W-1:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DATA_W-1:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DATA_W-1:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [KEY_W-1:0]  KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [KEY_W-1:0]  KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [KEY_W-1:0]  KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx_valid;
  logic [FRAME_W-1:0] rx_frame;
  logic [FRAME_W-1:0] tx_frame;
  logic               tx_load;
  logic               core_start;
  logic               core_decrypt;
  logic [1:0]         core_keylen;
  logic [DATA_W-1:0]  core_data;
  logic [KEY_W-1:0]   core_key;
  logic               core_done;
  logic [DATA_W-1:0]  core_result;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int n_tx = 0;
  int n_start = 0;

  aes_frame_ctrl #(
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W),
    .CTRL_W (CTRL_W),
    .FRAME_W(FRAME_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_frame    (rx_frame),
    .tx_frame    (tx_frame),
    .tx_load     (tx_load),
    .core_start  (core_start),
    .core_decrypt(core_decrypt),
    .core_keylen (core_keylen),
    .core_data   (core_data),
    .core_key    (core_key),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_load === 1'b1) n_tx++;
    if (core_start === 1'b1) n_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [7:0] c, input logic [KEY_W-1:0] k);
    rx_frame = {d, c, k};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_frame = '0; core_done = 1'b0; core_result = '0;
    tick(); tick();
    checks++;
    if ({tx_load, core_start, core_decrypt, core_keylen, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {tx_load, core_start, core_decrypt, core_keylen, busy});
    end
    checks++;
    if ({tx_frame, core_data, core_key} !== '0) begin
      errors++; $display("FAIL reset_data got nonzero tx_frame/core_data/core_key want 0");
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_encrypt();
    int tx0 = n_tx;
    int st0 = n_start;
    logic bad = 1'b0;
    send(PT, 8'h10, KEY128);
    checks++;
    if ({busy, core_start} !== 2'b10) begin
      errors++; $display("FAIL t1_check_cycle got busy,start=%b want 10", {busy, core_start});
    end
    tick();
    checks++;
    if ({core_start, core_decrypt, core_keylen} !== 4'b1000) begin
      errors++; $display("FAIL t1_start got start,dec,klen=%b want 1000", {core_start, core_decrypt, core_keylen});
    end
    checks++;
    if (core_data !== PT || core_key !== KEY128) begin
      errors++; $display("FAIL t1_core_in got data=%h key=%h want data=%h key=%h", core_data, core_key, PT, KEY128);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (core_start !== 1'b0 || tx_load !== 1'b0 || core_data !== PT) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL t1_run_hold got bad=%b want 0", bad); end
    core_done = 1'b1; core_result = CT128;
    tick();
    core_done = 1'b0; core_result = '0;
    checks++;
    if (tx_load !== 1'b1) begin errors++; $display("FAIL t1_tx_load got %b want 1", tx_load); end
    checks++;
    if (tx_frame !== {CT128, 8'h01, 256'h0}) begin
      errors++; $display("FAIL t1_tx_frame got %h want %h", tx_frame, {CT128, 8'h01, 256'h0});
    end
    tick();
    checks++;
    if ({tx_load, busy} !== 2'b00 || tx_frame !== {CT128, 8'h01, 256'h0}) begin
      errors++; $display("FAIL t1_after got load,busy=%b frame=%h", {tx_load, busy}, tx_frame);
    end
    checks++;
    if (n_tx - tx0 != 1 || n_start - st0 != 1) begin
      errors++; $display("FAIL t1_pulses got tx=%0d start=%0d want 1 1", n_tx - tx0, n_start - st0);
    end
  endtask

  task automatic test_decrypt();
    logic bad = 1'b0;
    send(CT192, 8'h98, KEY192);
    tick();
    checks++;
    if ({core_start, core_decrypt, core_keylen} !== 4'b1101 || core_key !== KEY192 || core_data !== CT192) begin
      errors++; $display("FAIL t2_start got start,dec,klen=%b key=%h", {core_start, core_decrypt, core_keylen}, core_key);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_decrypt !== 1'b1 || core_keylen !== 2'd1 || core_key !== KEY192) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL t2_hold got bad=%b want 0", bad); end
    core_done = 1'b1; core_result = PT;
    tick();
    core_done = 1'b0; core_result = '0;
    checks++;
    if (tx_load !== 1'b1 || tx_frame !== {PT, 8'h01, 256'h0}) begin
      errors++; $display("FAIL t2_resp got load=%b frame=%h want 1 %h", tx_load, tx_frame, {PT, 8'h01, 256'h0});
    end
    tick();
  endtask

  task automatic test_badlen();
    int st0 = n_start;
    send(PT, 8'h11, KEY128);
    checks++;
    if (tx_load !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t3_check got load=%b busy=%b want 0 1", tx_load, busy);
    end
    tick();
    checks++;
    if (tx_load !== 1'b1 || tx_frame !== {128'h0, 8'h02, 256'h0}) begin
      errors++; $display("FAIL t3_resp got load=%b frame=%h want 1 %h", tx_load, tx_frame, {128'h0, 8'h02, 256'h0});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || n_start != st0) begin
      errors++; $display("FAIL t3_no_start got busy=%b starts=%0d want 0 0", busy, n_start - st0);
    end
  endtask

  task automatic test_timeout();
    logic bad = 1'b0;
    send(PT, 8'h20, KEY256);
    tick();
    checks++;
    if (core_start !== 1'b1 || core_keylen !== 2'd2) begin
      errors++; $display("FAIL t4_start got start=%b klen=%0d want 1 2", core_start, core_keylen);
    end
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      if (tx_load !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL t4_early got early tx_load=%b want 0", bad); end
    tick();
    checks++;
    if (tx_load !== 1'b1 || tx_frame !== {128'h0, 8'h04, 256'h0}) begin
      errors++; $display("FAIL t4_resp got load=%b frame=%h want 1 %h", tx_load, tx_frame, {128'h0, 8'h04, 256'h0});
    end
    tick();
  endtask

  task automatic test_done_on_timeout();
    send(PT, 8'h10, KEY128);
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    core_done = 1'b1; core_result = CT128;
    tick();
    core_done = 1'b0; core_result = '0;
    checks++;
    if (tx_load !== 1'b1 || tx_frame !== {CT128, 8'h01, 256'h0}) begin
      errors++; $display("FAIL done_wins got load=%b frame=%h want 1 %h", tx_load, tx_frame, {CT128, 8'h01, 256'h0});
    end
    tick();
  endtask

  task automatic test_overrun();
    int st0 = n_start;
    send(PT, 8'h10, KEY128);
    tick();
    send(CT192, 8'h11, KEY192);
    tick(); tick();
    checks++;
    if (core_data !== PT || core_key !== KEY128) begin
      errors++; $display("FAIL t5_dropped got data=%h want %h", core_data, PT);
    end
    core_done = 1'b1; core_result = CT128;
    tick();
    core_done = 1'b0;
    checks++;
    if (tx_load !== 1'b1 || tx_frame !== {CT128, 8'h09, 256'h0}) begin
      errors++; $display("FAIL t5_ovr_status got load=%b frame=%h want 1 %h", tx_load, tx_frame, {CT128, 8'h09, 256'h0});
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || n_start - st0 != 1) begin
      errors++; $display("FAIL t5_single got busy=%b starts=%0d want 0 1", busy, n_start - st0);
    end
    send(CT192, 8'h98, KEY192);
    tick(); tick(); tick();
    core_done = 1'b1; core_result = PT;
    tick();
    core_done = 1'b0; core_result = '0;
    checks++;
    if (tx_load !== 1'b1 || tx_frame !== {PT, 8'h01, 256'h0}) begin
      errors++; $display("FAIL t5_cleared got load=%b frame=%h want 1 %h", tx_load, tx_frame, {PT, 8'h01, 256'h0});
    end
    tick();
  endtask

  task automatic test_stray();
    int tx0 = n_tx;
    core_done = 1'b1; core_result = CT128;
    tick();
    core_done = 1'b0; core_result = '0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || n_tx != tx0 || tx_frame !== {PT, 8'h01, 256'h0}) begin
      errors++; $display("FAIL stray_done got busy=%b tx=%0d frame=%h want 0 0 held", busy, n_tx - tx0, tx_frame);
    end
  endtask

  task automatic test_reset_mid_run();
    int tx0;
    send(CT192, 8'h98, KEY192);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx0 = n_tx;
    checks++;
    if ({tx_load, core_start, core_decrypt, core_keylen, busy} !== 6'b0 || {tx_frame, core_data, core_key} !== '0) begin
      errors++; $display("FAIL t6_reset got ctrl=%b frame=%h", {tx_load, core_start, core_decrypt, core_keylen, busy}, tx_frame);
    end
    core_done = 1'b1; core_result = PT;
    tick();
    core_done = 1'b0; core_result = '0;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b0 || tx_load !== 1'b0 || n_tx != tx0) begin
      errors++; $display("FAIL t6_after got busy=%b load=%b tx=%0d want 0 0 0", busy, tx_load, n_tx - tx0);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_badlen();
    test_timeout();
    test_done_on_timeout();
    test_overrun();
    test_stray();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
